ula_ar: RTL and testbench



---
 rtl/ula_ar.sv | 87 ++++++++
 tb/tb_ula_ar.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/ula_ar.sv
// rtl/ula_ar.sv - registered signed arithmetic unit with overflow/carry/sign/zero flags
module ula_ar #(
    parameter int bits = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [bits-1:0] A,
    input  logic [bits-1:0] B,
    input  logic [4:0]      OP,
    output logic [bits-1:0] RESU,
    output logic            O,
    output logic            C,
    output logic            S,
    output logic            Z
);

    localparam int msb = bits - 1;

    typedef enum logic [4:0] {
        op_add   = 5'b00000,
        op_addc1 = 5'b00001,
        op_inca  = 5'b00010,
        op_sub   = 5'b00011,
        op_subd1 = 5'b00100,
        op_deca  = 5'b00101,
        op_nega  = 5'b00110,
        op_negb  = 5'b00111,
        op_passa = 5'b01000,
        op_passb = 5'b01001
    } op_t;

    logic [bits-1:0] x;
    logic [bits-1:0] y;
    logic            cin;
    logic            valid;
    logic            pass;
    logic [bits:0]   sum;
    logic [bits-1:0] res_n;
    logic            o_n;
    logic            c_n;

    // Every operation is folded onto a single adder by choosing X, Y and carry-in.
    always_comb begin
        x     = '0;
        y     = '0;
        cin   = 1'b0;
        valid = 1'b1;
        pass  = 1'b0;
        case (OP)
            op_add:   begin x = A;  y = B;             end
            op_addc1: begin x = A;  y = B;  cin = 1'b1; end
            op_inca:  begin x = A;          cin = 1'b1; end
            op_sub:   begin x = A;  y = ~B; cin = 1'b1; end
            op_subd1: begin x = A;  y = ~B;            end
            op_deca:  begin x = A;  y = '1;            end
            op_nega:  begin         y = ~A; cin = 1'b1; end
            op_negb:  begin         y = ~B; cin = 1'b1; end
            op_passa: begin x = A;  pass = 1'b1;       end
            op_passb: begin x = B;  pass = 1'b1;       end
            default:  valid = 1'b0;
        endcase
    end

    always_comb begin
        sum   = {1'b0, x} + {1'b0, y} + {{bits{1'b0}}, cin};
        res_n = valid ? sum[bits-1:0] : '0;
        c_n   = valid && !pass && sum[bits];
        o_n   = valid && !pass && (x[msb] == y[msb]) && (sum[msb] != x[msb]);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            RESU <= '0;
            O    <= 1'b0;
            C    <= 1'b0;
            S    <= 1'b0;
            Z    <= 1'b0;
        end else begin
            RESU <= res_n;
            O    <= o_n;
            C    <= c_n;
            S    <= res_n[msb];
            Z    <= (res_n == '0);
        end
    end

endmodule

// File: tb/tb_ula_ar.sv
// tb/tb_ula_ar.sv - table-driven and scoreboard bench for ula_ar
module tb_ula_ar;

    localparam int W = 3;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic [4:0]   OP = '0;
    logic [W-1:0] RESU;
    logic         O, C, S, Z;

    int checks = 0;
    int errors = 0;

    // expected record: {resu, o, c, s, z}
    logic [6:0] sb[$];

    typedef struct {
        string      name;
        logic [4:0] op;
        logic [2:0] a;
        logic [2:0] b;
        logic [6:0] exp;
    } vec_t;

    vec_t vecs[$];

    ula_ar #(.bits(W)) dut (
        .clk(clk), .reset(reset), .A(A), .B(B), .OP(OP),
        .RESU(RESU), .O(O), .C(C), .S(S), .Z(Z)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic logic [6:0] model(logic [4:0] op, logic [2:0] a, logic [2:0] b);
        int sa, sbv, ua, ub, r;
        logic c, o, s, z;
        logic [2:0] res;
        sa = $signed(a);
        sbv = $signed(b);
        ua = int'(a);
        ub = int'(b);
        case (op)
            5'd0: begin r = sa + sbv;     c = (ua + ub) >= 8;     end
            5'd1: begin r = sa + sbv + 1; c = (ua + ub + 1) >= 8; end
            5'd2: begin r = sa + 1;       c = (ua == 7);          end
            5'd3: begin r = sa - sbv;     c = (ua >= ub);         end
            5'd4: begin r = sa - sbv - 1; c = (ua > ub);          end
            5'd5: begin r = sa - 1;       c = (ua != 0);          end
            5'd6: begin r = -sa;          c = (ua == 0);          end
            5'd7: begin r = -sbv;         c = (ub == 0);          end
            5'd8: begin r = sa;           c = 1'b0;               end
            5'd9: begin r = sbv;          c = 1'b0;               end
            default: return 7'b000_0001;
        endcase
        o = (r > 3) || (r < -4);
        res = r[2:0];
        s = res[2];
        z = (res == 3'b000);
        return {res, o, c, s, z};
    endfunction

    task automatic cmp(string name, logic [6:0] exp);
        logic [6:0] act;
        act = {RESU, O, C, S, Z};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got resu=%b o=%b c=%b s=%b z=%b, expected resu=%b o=%b c=%b s=%b z=%b",
                     name, act[6:4], act[3], act[2], act[1], act[0],
                     exp[6:4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic drive(logic [4:0] op, logic [2:0] a, logic [2:0] b, logic [6:0] exp);
        OP = op;
        A = a;
        B = b;
        sb.push_back(exp);
    endtask

    task automatic edge_check(string name);
        logic [6:0] exp;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty, got resu=%b", name, RESU);
        end else begin
            exp = sb.pop_front();
            cmp(name, exp);
        end
    endtask

    initial begin
        logic [6:0] prev;
        logic [4:0] rop;
        logic [2:0] ra, rb;

        vecs.push_back('{"add_cancel", 5'b00000, 3'b010, 3'b110, {3'b000, 1'b0, 1'b1, 1'b0, 1'b1}});
        vecs.push_back('{"negb_eq_a",  5'b00111, 3'b000, 3'b110, {3'b010, 1'b0, 1'b0, 1'b0, 1'b0}});
        vecs.push_back('{"add_ovf",    5'b00000, 3'b011, 3'b001, {3'b100, 1'b1, 1'b0, 1'b1, 1'b0}});
        vecs.push_back('{"sub_ovf",    5'b00011, 3'b100, 3'b001, {3'b011, 1'b1, 1'b1, 1'b0, 1'b0}});
        vecs.push_back('{"sub_borrow", 5'b00011, 3'b001, 3'b010, {3'b111, 1'b0, 1'b0, 1'b1, 1'b0}});
        vecs.push_back('{"nega_min",   5'b00110, 3'b100, 3'b000, {3'b100, 1'b1, 1'b0, 1'b1, 1'b0}});
        vecs.push_back('{"inca_max",   5'b00010, 3'b011, 3'b000, {3'b100, 1'b1, 1'b0, 1'b1, 1'b0}});
        vecs.push_back('{"deca_min",   5'b00101, 3'b100, 3'b000, {3'b011, 1'b1, 1'b1, 1'b0, 1'b0}});
        vecs.push_back('{"unused_op",  5'b11111, 3'b101, 3'b011, {3'b000, 1'b0, 1'b0, 1'b0, 1'b1}});
        vecs.push_back('{"nega_zero",  5'b00110, 3'b000, 3'b101, {3'b000, 1'b0, 1'b1, 1'b0, 1'b1}});
        vecs.push_back('{"negb_min",   5'b00111, 3'b010, 3'b100, {3'b100, 1'b1, 1'b0, 1'b1, 1'b0}});
        vecs.push_back('{"addc1",      5'b00001, 3'b011, 3'b011, {3'b111, 1'b1, 1'b0, 1'b1, 1'b0}});
        vecs.push_back('{"subd1",      5'b00100, 3'b010, 3'b001, {3'b000, 1'b0, 1'b1, 1'b0, 1'b1}});
        vecs.push_back('{"passa_neg",  5'b01000, 3'b110, 3'b001, {3'b110, 1'b0, 1'b0, 1'b1, 1'b0}});
        vecs.push_back('{"passb",      5'b01001, 3'b110, 3'b001, {3'b001, 1'b0, 1'b0, 1'b0, 1'b0}});
        vecs.push_back('{"unused_01010", 5'b01010, 3'b111, 3'b111, {3'b000, 1'b0, 1'b0, 1'b0, 1'b1}});

        // reset state
        #3;
        cmp("reset_state", 7'b0);
        @(posedge clk);
        #1;
        cmp("reset_held_over_edge", 7'b0);
        @(negedge clk);
        reset = 1'b0;

        drive(5'b00000, 3'b001, 3'b001, {3'b010, 1'b0, 1'b0, 1'b0, 1'b0});
        edge_check("add_after_reset");

        foreach (vecs[i]) begin
            drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);
            edge_check(vecs[i].name);
        end

        // async reset with a nonzero result showing and a different one pending
        drive(5'b00000, 3'b011, 3'b001, model(5'b00000, 3'b011, 3'b001));
        edge_check("pre_reset_add");
        OP = 5'b00011; A = 3'b001; B = 3'b010;
        #2;
        reset = 1'b1;
        #1;
        cmp("async_reset_clears", 7'b0);
        @(posedge clk);
        #1;
        cmp("pending_discarded", 7'b0);
        @(negedge clk);
        reset = 1'b0;
        drive(5'b00000, 3'b001, 3'b001, {3'b010, 1'b0, 1'b0, 1'b0, 1'b0});
        edge_check("add_after_midreset");

        // inputs change every cycle; outputs must hold until the following edge
        for (int i = 0; i < 200; i++) begin
            prev = {RESU, O, C, S, Z};
            rop = 5'($urandom_range(0, 12));
            ra = 3'($urandom);
            rb = 3'($urandom);
            drive(rop, ra, rb, model(rop, ra, rb));
            #1;
            cmp("hold_between_edges", prev);
            edge_check("stream");
        end

        // exhaustive sweep of defined opcodes against the model
        for (int op = 0; op < 10; op++)
            for (int a = 0; a < 8; a++)
                for (int b = 0; b < 8; b++) begin
                    drive(5'(op), 3'(a), 3'(b), model(5'(op), 3'(a), 3'(b)));
                    edge_check("sweep");
                end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
